multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory port, register file, IR/MDR/A/B/ALUOut latches.
- Replaces the single-cycle opcode decoder. Drives per-state control strobes and waits on a memory acknowledge handshake.
- Supports R-type, addi, lw, sw, beq and j.
- Flags illegal opcodes and memory timeouts, then halts.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for mem_ack_i in any memory state before raising timeout_o; legal range 1..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  leave IDLE and begin fetching.
- Op_i  in  6  opcode from the IR.
- Zero_i  in  1  ALU zero flag.
- mem_ack_i  in  1  memory transfer complete this cycle.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if Zero_i.
- IorD_o  out  1  0 = PC address, 1 = ALUOut address.
- MemRead_o  out  1  memory read request, held until ack.
- MemWrite_o  out  1  memory write request, held until ack.
- IRWrite_o  out  1  latch IR.
- MemtoReg_o  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegDst_o  out  1  1 = rd, 0 = rt.
- RegWrite_o  out  1  register file write enable.
- ALUSrcA_o  out  1  0 = PC, 1 = A.
- ALUSrcB_o  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- busy_o  out  1  high in every state except IDLE and HALT.
- illegal_o  out  1  sticky; undefined opcode decoded.
- timeout_o  out  1  sticky; MEM_TIMEOUT expired.

Behaviour:
- Reset: state = IDLE, timeout counter = 0, all outputs 0. Reset wins over every other input, including mid-transfer; the request drops on the next cycle.
- Outputs are a pure function of state (Moore). Exception: PCWrite_o/IRWrite_o in FETCH assert only in the cycle mem_ack_i = 1.
- IDLE: all outputs 0. Go to FETCH when start_i = 1.
- FETCH:
  - MemRead_o = 1, IorD_o = 0, ALUSrcA_o = 0, ALUSrcB_o = 01, ALUOp_o = 00, PCSource_o = 00.
  - On ack: IRWrite_o = 1, PCWrite_o = 1, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA_o = 0, ALUSrcB_o = 11, ALUOp_o = 00. Branch on Op_i:
  - 000000 -> EXEC_R; 001000 -> EXEC_I.
  - 100011 / 101011 -> MEM_ADDR.
  - 000100 -> BRANCH; 000010 -> JUMP.
  - Anything else -> HALT with illegal_o = 1.
- EXEC_R: ALUSrcA_o = 1, ALUSrcB_o = 00, ALUOp_o = 10 -> R_WB.
- R_WB: RegDst_o = 1, MemtoReg_o = 0, RegWrite_o = 1 -> FETCH.
- EXEC_I: ALUSrcA_o = 1, ALUSrcB_o = 10, ALUOp_o = 00 -> I_WB.
- I_WB: RegDst_o = 0, MemtoReg_o = 0, RegWrite_o = 1 -> FETCH.
- MEM_ADDR: same ALU settings as EXEC_I. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead_o = 1, IorD_o = 1. On ack -> MEM_WB.
- MEM_WB: RegDst_o = 0, MemtoReg_o = 1, RegWrite_o = 1 -> FETCH.
- MEM_WR: MemWrite_o = 1, IorD_o = 1. On ack -> FETCH.
- BRANCH: ALUSrcA_o = 1, ALUSrcB_o = 00, ALUOp_o = 01, PCWriteCond_o = 1, PCSource_o = 01 -> FETCH.
- JUMP: PCWrite_o = 1, PCSource_o = 10 -> FETCH.
- HALT: all strobes 0, busy_o = 0. Stays until rst_i.
- Timeout counter:
  - Clears on entry to each memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle without ack.
  - When count = MEM_TIMEOUT and no ack that cycle -> HALT with timeout_o = 1.
  - Ack in the same cycle as expiry counts as success.
- Cycle counts with single-cycle ack: R/addi/sw = 4, lw = 5, beq/j = 3.
- start_i is ignored outside IDLE.
- mem_ack_i is ignored outside memory states.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Enabled: adds outputs cycle_cnt_o[31:0] and instr_cnt_o[31:0].
  - cycle_cnt_o increments every busy_o cycle.
  - instr_cnt_o increments on each transition into FETCH from a completion state.
  - Both clear on rst_i and wrap modulo 2^32.
- Disabled: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT);
  - opcode constants OP_RTYPE/OP_ADDI/OP_LW/OP_SW/OP_BEQ/OP_J;
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mc_mem_watchdog: timeout counter with clear/tick/expired interface.

Test Plan:
- rst_i = 1 for 2 cycles, then start_i = 1, ack always 1, Op_i = 000000 -> FETCH, DECODE, EXEC_R, R_WB; RegWrite_o = 1 and RegDst_o = 1 in cycle 4; back in FETCH at cycle 5.
- lw (100011) with ack delayed 3 cycles in MEM_RD -> MemRead_o held high 4 cycles with IorD_o = 1; MEM_WB has MemtoReg_o = 1.
- beq (000100), Zero_i = 1 -> PCWriteCond_o = 1, PCSource_o = 01, ALUOp_o = 01 in BRANCH.
- Op_i = 111111 in DECODE -> HALT; illegal_o = 1 sticky; busy_o = 0 until rst_i.
- MEM_TIMEOUT = 3, ack never asserted in FETCH -> HALT after 4 FETCH cycles with timeout_o = 1. A repeat with ack in the 4th cycle must proceed to DECODE.
- rst_i asserted during MEM_WR wait -> next cycle MemWrite_o = 0, state IDLE, flags cleared.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, the opcodes the controller understands and
// the encodings of the ALUOp, ALUSrcB and PCSource datapath selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        EXEC_I   = 4'd5,
        I_WB     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        HALT     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a request on the memory port and wait for mem_ack_i.
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory-wait watchdog for the multicycle controller.
// Counts cycles spent waiting for a memory acknowledge.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset, clears the count
//   clear_i   : restart the count (takes priority over tick_i)
//   tick_i    : one more cycle passed without an acknowledge
//   expired_o : count has reached LIMIT
module mc_mem_watchdog #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: reset/clear to zero, otherwise advance on each tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_i) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = (cnt_r == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback for R-type, addi, lw, sw,
// beq and j; waits on mem_ack_i in memory states; halts on an illegal
// opcode or a memory timeout with sticky illegal_o / timeout_o flags.
// Inputs : clk_i, rst_i (sync, active high), start_i, Op_i[5:0], Zero_i,
//          mem_ack_i.
// Outputs: datapath strobes PCWrite_o .. PCSource_o, busy_o, illegal_o,
//          timeout_o. When MULTICYCLE_PERF_EN is defined, also
//          cycle_cnt_o[31:0] (busy cycles) and instr_cnt_o[31:0]
//          (completed instructions).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] Op_i,
    input  logic       Zero_i,
    input  logic       mem_ack_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic       busy_o,
    output logic       illegal_o,
    output logic       timeout_o
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
`endif
);

    state_e state_r;
    state_e state_next_s;
    logic   mem_state_s;
    logic   wd_expired_s;
    logic   illegal_set_s;
    logic   timeout_set_s;
    logic   illegal_r;
    logic   timeout_r;
    logic   unused_zero_s;

    // The branch condition is applied in the datapath through PCWriteCond_o.
    assign unused_zero_s = Zero_i;

    assign mem_state_s   = is_mem_state(state_r);
    assign timeout_set_s = mem_state_s && !mem_ack_i && wd_expired_s;

    // Any state change restarts the count, so each memory state starts at 0.
    mc_mem_watchdog #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_next_s != state_r),
        .tick_i    (mem_state_s && !mem_ack_i),
        .expired_o (wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | illegal_set_s;
            timeout_r <= timeout_r | timeout_set_s;
        end
    end

    assign illegal_o = illegal_r;
    assign timeout_o = timeout_r;

    // Next-state logic; an acknowledge on the expiry cycle still succeeds.
    always_comb begin
        state_next_s  = state_r;
        illegal_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (mem_ack_i) begin
                    state_next_s = DECODE;
                end else if (wd_expired_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                case (Op_i)
                    OP_RTYPE: state_next_s = EXEC_R;
                    OP_ADDI:  state_next_s = EXEC_I;
                    OP_LW:    state_next_s = MEM_ADDR;
                    OP_SW:    state_next_s = MEM_ADDR;
                    OP_BEQ:   state_next_s = BRANCH;
                    OP_J:     state_next_s = JUMP;
                    default: begin
                        state_next_s  = HALT;
                        illegal_set_s = 1'b1;
                    end
                endcase
            end
            EXEC_R:   state_next_s = R_WB;
            R_WB:     state_next_s = FETCH;
            EXEC_I:   state_next_s = I_WB;
            I_WB:     state_next_s = FETCH;
            MEM_ADDR: begin
                if (Op_i == OP_LW) begin
                    state_next_s = MEM_RD;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            MEM_RD: begin
                if (mem_ack_i) begin
                    state_next_s = MEM_WB;
                end else if (wd_expired_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = MEM_RD;
                end
            end
            MEM_WB:   state_next_s = FETCH;
            MEM_WR: begin
                if (mem_ack_i) begin
                    state_next_s = FETCH;
                end else if (wd_expired_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            BRANCH:   state_next_s = FETCH;
            JUMP:     state_next_s = FETCH;
            HALT:     state_next_s = HALT;
            default:  state_next_s = HALT;
        endcase
    end

    // Per-state control strobes; only the FETCH PC/IR loads look at mem_ack_i.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = SRCB_B;
        ALUOp_o       = ALUOP_ADD;
        PCSource_o    = PCSRC_ALU;
        busy_o        = 1'b1;
        case (state_r)
            IDLE: busy_o = 1'b0;
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = SRCB_FOUR;
                PCWrite_o = mem_ack_i;
                IRWrite_o = mem_ack_i;
            end
            DECODE: ALUSrcB_o = SRCB_IMM_SH;
            EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALUOP_FUNCT;
            end
            R_WB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            I_WB: RegWrite_o = 1'b1;
            MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            MEM_WB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALUOP_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCSRC_JUMP;
            end
            HALT:    busy_o = 1'b0;
            default: busy_o = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] instr_cnt_r;
    logic        instr_done_s;

    // An instruction completes when a final state hands back to FETCH.
    assign instr_done_s = (state_next_s == FETCH) &&
                          ((state_r == R_WB) || (state_r == I_WB) ||
                           (state_r == MEM_WB) || (state_r == MEM_WR) ||
                           (state_r == BRANCH) || (state_r == JUMP));

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_r <= 32'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + {31'd0, busy_o};
            instr_cnt_r <= instr_cnt_r + {31'd0, instr_done_s};
        end
    end

    assign cycle_cnt_o = cycle_cnt_r;
    assign instr_cnt_o = instr_cnt_r;
`endif

endmodule
